fib_pair_serializer: RTL and testbench

FIB_PAIR_SERIALIZER -- requirements
Module: fib_pair_serializer

---
 rtl/fib_pair_serializer_pkg.sv | 18 +
 rtl/fib_pair_serializer.sv | 93 +++++++++
 tb/tb_fib_pair_serializer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/fib_pair_serializer_pkg.sv
// Shared types and constants for the pair-to-word serializer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package fib_pair_serializer_pkg;

    // Default data word width in bits.
    localparam int DEFAULT_WIDTH = 16;

    // EMPTY: nothing held
    // TWO:   both words held, data0 is on the output
    // ONE:   only data1 still pending
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        TWO   = 2'd1,
        ONE   = 2'd2
    } state_t;

endpackage : fib_pair_serializer_pkg

// File: rtl/fib_pair_serializer.sv
// Serializes a two-words-per-transfer stream into one word per cycle, data0 first.
// Latency: one cycle; a pair accepted at edge N shows data0 on out_data after edge N.
// Backpressure: in_ready=0 while data0 is pending; in ONE it follows out_ready so a new pair
// can be taken on the same edge that data1 leaves, giving a bubble-free word stream.
//
// Ports:
//   clk, rst              single clock, synchronous active-high reset
//   in_valid/in_ready     pair handshake; in_data0 (older) and in_data1 (newer) words
//   out_valid/out_ready   word handshake; out_data is the serialized word
module fib_pair_serializer
    import fib_pair_serializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data0,
    input  logic [WIDTH-1:0] in_data1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] data0_q;
    logic [WIDTH-1:0] data1_q;
    logic             load_pair;

    // Outputs are decoded from registered state and holding registers only;
    // the one combinational input-to-output path is out_ready -> in_ready in ONE.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        load_pair = 1'b0;
        // data1_q is also what EMPTY shows: it stays at the last word of the
        // last pair, so out_data is stable while nothing is held.
        out_data  = data1_q;

        case (state_q)
            EMPTY: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load_pair = 1'b1;
                    state_d   = TWO;
                end
            end
            TWO: begin
                out_valid = 1'b1;
                out_data  = data0_q;
                if (out_ready) begin
                    state_d = ONE;
                end
            end
            ONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    // data1 leaves this edge; refill immediately if a pair is offered.
                    load_pair = in_valid;
                    state_d   = in_valid ? TWO : EMPTY;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase

        // Nothing may be accepted while reset is asserted.
        if (rst) begin
            in_ready  = 1'b0;
            load_pair = 1'b0;
        end
    end

    // Holding registers are not cleared by reset; the state alone decides
    // whether their contents are meaningful.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
        if (load_pair) begin
            data0_q <= in_data0;
            data1_q <= in_data1;
        end
    end

endmodule : fib_pair_serializer

// File: tb/tb_fib_pair_serializer.sv
// Self-checking bench for fib_pair_serializer: directed steps plus a random-backpressure run.
// Each step drives inputs 1ns after the rising edge and samples outputs 1ns later.
// Expected words come from a queue filled as pairs are accepted; handshake flags from word count held.
module tb_fib_pair_serializer;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data0;
    logic [W-1:0] in_data1;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;

    int checks = 0;
    int errors = 0;
    int nout   = 0;

    logic [W-1:0] sb_q[$];
    logic [W-1:0] fib[0:19];

    always #5 clk = ~clk;

    fib_pair_serializer #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data0 (in_data0),
        .in_data1 (in_data1),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock cycle: drive, check against the model, update the model, advance.
    task automatic step(input logic r, input logic iv, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic ordy, output logic acc);
        logic exp_ov;
        logic exp_ir;
        rst       = r;
        in_valid  = iv;
        in_data0  = a;
        in_data1  = b;
        out_ready = ordy;
        #1;
        exp_ov = (sb_q.size() != 0);
        exp_ir = !r && ((sb_q.size() == 0) || (sb_q.size() == 1 && ordy));
        chk("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ir});
        if (exp_ov) begin
            chk("out_data", {16'd0, out_data}, {16'd0, sb_q[0]});
        end
        acc = 1'b0;
        if (r) begin
            sb_q.delete();
        end else begin
            if (exp_ov && ordy) begin
                void'(sb_q.pop_front());
                nout++;
            end
            if (iv && exp_ir) begin
                sb_q.push_back(a);
                sb_q.push_back(b);
                acc = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic acc;
        int   idx;
        int   steps;
        int   n0;
        logic [W-1:0] pa[0:3];
        logic [W-1:0] pb[0:3];

        fib[0] = 16'd1;
        fib[1] = 16'd1;
        for (int i = 2; i < 20; i++) fib[i] = fib[i-1] + fib[i-2];

        rst = 1'b1; in_valid = 1'b0; in_data0 = '0; in_data1 = '0; out_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset held: no output, not ready, even with a pair offered.
        step(1'b1, 1'b1, 16'hAAAA, 16'h5555, 1'b1, acc);
        step(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, acc);

        // Free flow: 4 pairs, outputs on consecutive cycles.
        pa[0] = 16'd1;  pb[0] = 16'd1;
        pa[1] = 16'd2;  pb[1] = 16'd3;
        pa[2] = 16'd5;  pb[2] = 16'd8;
        pa[3] = 16'd13; pb[3] = 16'd21;
        idx = 0; steps = 0; n0 = nout;
        while ((idx < 4 || sb_q.size() != 0) && steps < 30) begin
            if (idx < 4) step(1'b0, 1'b1, pa[idx], pb[idx], 1'b1, acc);
            else         step(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, acc);
            if (acc) idx++;
            steps++;
        end
        chk("free_flow_cycles", steps, 9);
        chk("free_flow_words", nout - n0, 8);

        // Backpressure in TWO: 2 held, offered pair ignored, then 2, 3.
        step(1'b0, 1'b1, 16'd2, 16'd3, 1'b0, acc);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'h0099, 16'h0099, 1'b0, acc);
        step(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, acc);
        step(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, acc);
        step(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, acc);

        // Sparse single pair: 5, 8, then empty.
        step(1'b0, 1'b1, 16'd5, 16'd8, 1'b1, acc);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, acc);

        // Stall in ONE with a pair offered: not taken until out_ready, then 21, 34, 55.
        step(1'b0, 1'b1, 16'd13, 16'd21, 1'b1, acc);
        step(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, acc);
        step(1'b0, 1'b1, 16'd34, 16'd55, 1'b0, acc);
        step(1'b0, 1'b1, 16'd34, 16'd55, 1'b0, acc);
        step(1'b0, 1'b1, 16'd34, 16'd55, 1'b1, acc);
        chk("one_refill_accept", {31'd0, acc}, 32'd1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, acc);

        // Reset mid-pair in ONE: held word discarded, next pair clean.
        step(1'b0, 1'b1, 16'd7, 16'd9, 1'b1, acc);
        step(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, acc);
        step(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, acc);
        step(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, acc);
        step(1'b0, 1'b1, 16'd1, 16'd1, 1'b1, acc);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, acc);

        // Bit-exact extremes.
        step(1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b1, acc);
        step(1'b0, 1'b1, 16'h0000, 16'hFFFF, 1'b1, acc);
        step(1'b0, 1'b1, 16'h0000, 16'hFFFF, 1'b1, acc);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, acc);

        // Fibonacci pair stream under random valid/ready, 20 words.
        idx = 0; steps = 0; n0 = nout;
        while ((idx < 10 || sb_q.size() != 0) && steps < 400) begin
            if (idx < 10 && $urandom_range(0, 3) != 0)
                step(1'b0, 1'b1, fib[2*idx], fib[2*idx+1], 1'($urandom_range(0, 1)), acc);
            else
                step(1'b0, 1'b0, 16'h0, 16'h0, 1'($urandom_range(0, 1)), acc);
            if (acc) idx++;
            steps++;
        end
        chk("random_pairs", idx, 10);
        chk("random_words", nout - n0, 20);
        chk("sb_empty", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fib_pair_serializer
